// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-add multiplier: one WIDTH-bit ripple adder of 1-bit cells, one iteration per clock.
// Optional macro SHIFT_ADD_ZERO_BYPASS_EN: zero operands complete in one cycle without entering RUN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_mult_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    acc_hi;
    logic [WIDTH-1:0]    acc_lo;
    logic [CW-1:0]       count;

    logic [WIDTH-1:0]    addend;
    logic [WIDTH-1:0]    sum;
    logic [WIDTH:0]      c;
    logic [2*WIDTH-1:0]  nxt;

    assign addend = acc_lo[0] ? mcand : '0;
    assign c[0]   = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (acc_hi[i]),
            .b    (addend[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    // Carry-out is shifted in as the new MSB, so the full product never overflows.
    assign nxt = {c[WIDTH], sum, acc_lo[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            P      <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= A;
                        acc_lo <= B;
                        acc_hi <= '0;
                        count  <= '0;
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
                        if (A == '0 || B == '0) begin
                            P     <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
`else
                        busy  <= 1'b1;
                        state <= RUN;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    {acc_hi, acc_lo} <= nxt;
                    count            <= count + 1'b1;
                    if (count == LAST) begin
                        P     <= nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
